// File: rtl/chess_pkg.sv
// Shared types for the chess move sequencer: square codes, piece types,
// colours and the controller state encoding.
package chess_pkg;

    typedef enum logic [2:0] {
        PT_NONE = 3'd0,
        PAWN    = 3'd1,
        KNIGHT  = 3'd2,
        BISHOP  = 3'd3,
        ROOK    = 3'd4,
        QUEEN   = 3'd5,
        KING    = 3'd6,
        PT_RSVD = 3'd7
    } piece_type_t;

    // Board square code as stored in the board array
    typedef struct packed {
        piece_type_t ptype;
        logic        color;
        logic        occ;
    } piece_t;

    localparam piece_t EMPTY = piece_t'(5'b00000);
    localparam logic   WHITE = 1'b0;
    localparam logic   BLACK = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SELECTED  = 3'd1,
        CHECK     = 3'd2,
        WRITE_DST = 3'd3,
        CLEAR_SRC = 3'd4,
        OVER      = 3'd5
    } ctrl_state_t;

    // True when the square code holds a king of either colour
    function automatic logic is_king(input piece_t p);
        return p.occ && (p.ptype == KING);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already-synchronised button level.
// Stays disarmed for the first cycle after reset so a button held through
// reset never produces a spurious event.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic lvl,
    output logic evt
);

    logic prev_r;
    logic armed_r;

    // Remember the previous level and arm one cycle after reset releases
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            prev_r  <= lvl;
            armed_r <= 1'b1;
        end
    end

    assign evt = armed_r & lvl & ~prev_r;

endmodule

// File: rtl/chess_move_ctrl.sv
// Turn-based move sequencer: select, place, external legality check,
// two-cycle board commit (destination then source) and turn alternation.
// This block owns the only write port into the board array.
module chess_move_ctrl
    import chess_pkg::*;
#(
    parameter int CHK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       select_btn,
    input  logic       place_btn,
    input  logic [2:0] cur_row,
    input  logic [2:0] cur_col,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    input  logic [4:0] rd_data,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [4:0] wr_data,
    output logic       chk_req,
    output logic [4:0] chk_piece,
    output logic [5:0] chk_src,
    output logic [5:0] chk_dst,
    input  logic       chk_ack,
    input  logic       chk_legal,
    output logic       turn,
    output logic       sel_valid,
    output logic [2:0] sel_row,
    output logic [2:0] sel_col,
    output logic       err,
    output logic       move_done,
    output logic       game_over
);

    localparam int CW = $clog2(CHK_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(CHK_TIMEOUT - 1);
    localparam logic [CW-1:0] TMO_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] TMO_ONE  = CW'(1);

    logic        sel_evt_s;
    logic        plc_evt_s;
    logic        both_evt_s;
    logic        at_src_s;
    logic        own_s;
    piece_t      cur_code_s;

    ctrl_state_t state_r;
    piece_t      piece_r;
    piece_t      dst_code_r;
    logic [2:0]  dst_row_r;
    logic [2:0]  dst_col_r;
    logic [CW-1:0] tmo_cnt_r;

    btn_edge u_sel_edge (
        .clk   (clk),
        .reset (reset),
        .lvl   (select_btn),
        .evt   (sel_evt_s)
    );

    btn_edge u_plc_edge (
        .clk   (clk),
        .reset (reset),
        .lvl   (place_btn),
        .evt   (plc_evt_s)
    );

    // The board is always read at the cursor square
    assign rd_row = cur_row;
    assign rd_col = cur_col;

    assign cur_code_s = piece_t'(rd_data);
    assign both_evt_s = sel_evt_s & plc_evt_s;
    assign at_src_s   = (cur_row == sel_row) && (cur_col == sel_col);
    assign own_s      = cur_code_s.occ && (cur_code_s.color == turn);

    // Move sequencing FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            turn       <= WHITE;
            sel_valid  <= 1'b0;
            sel_row    <= 3'd0;
            sel_col    <= 3'd0;
            chk_req    <= 1'b0;
            chk_piece  <= 5'd0;
            chk_src    <= 6'd0;
            chk_dst    <= 6'd0;
            wr_en      <= 1'b0;
            wr_row     <= 3'd0;
            wr_col     <= 3'd0;
            wr_data    <= 5'd0;
            err        <= 1'b0;
            move_done  <= 1'b0;
            game_over  <= 1'b0;
            piece_r    <= EMPTY;
            dst_code_r <= EMPTY;
            dst_row_r  <= 3'd0;
            dst_col_r  <= 3'd0;
            tmo_cnt_r  <= {CW{1'b0}};
        end else begin
            // Pulses default low every cycle
            err       <= 1'b0;
            move_done <= 1'b0;
            wr_en     <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (both_evt_s) begin
                        err <= 1'b1;
                    end else if (sel_evt_s) begin
                        if (own_s) begin
                            piece_r   <= cur_code_s;
                            sel_row   <= cur_row;
                            sel_col   <= cur_col;
                            sel_valid <= 1'b1;
                            state_r   <= SELECTED;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (plc_evt_s) begin
                        err <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                SELECTED: begin
                    if (both_evt_s) begin
                        err <= 1'b1;
                    end else if (sel_evt_s) begin
                        if (at_src_s) begin
                            sel_valid <= 1'b0;
                            state_r   <= IDLE;
                        end else if (own_s) begin
                            piece_r <= cur_code_s;
                            sel_row <= cur_row;
                            sel_col <= cur_col;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (plc_evt_s) begin
                        if (at_src_s || own_s) begin
                            err <= 1'b1;
                        end else begin
                            dst_row_r  <= cur_row;
                            dst_col_r  <= cur_col;
                            dst_code_r <= cur_code_s;
                            chk_req    <= 1'b1;
                            chk_piece  <= piece_r;
                            chk_src    <= {sel_row, sel_col};
                            chk_dst    <= {cur_row, cur_col};
                            tmo_cnt_r  <= {CW{1'b0}};
                            state_r    <= CHECK;
                        end
                    end else begin
                        state_r <= SELECTED;
                    end
                end

                CHECK: begin
                    // Button events are deliberately ignored while the checker works
                    if (chk_ack) begin
                        chk_req <= 1'b0;
                        if (chk_legal) begin
                            wr_en   <= 1'b1;
                            wr_row  <= dst_row_r;
                            wr_col  <= dst_col_r;
                            wr_data <= piece_r;
                            state_r <= WRITE_DST;
                        end else begin
                            err       <= 1'b1;
                            sel_valid <= 1'b0;
                            state_r   <= IDLE;
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        chk_req   <= 1'b0;
                        err       <= 1'b1;
                        sel_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else if (tmo_cnt_r != TMO_MAX) begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r;
                    end
                end

                WRITE_DST: begin
                    // Destination written this cycle; schedule the source clear
                    wr_en     <= 1'b1;
                    wr_row    <= sel_row;
                    wr_col    <= sel_col;
                    wr_data   <= EMPTY;
                    move_done <= 1'b1;
                    sel_valid <= 1'b0;
                    turn      <= (turn == WHITE) ? BLACK : WHITE;
                    if (is_king(dst_code_r)) begin
                        game_over <= 1'b1;
                    end else begin
                        game_over <= game_over;
                    end
                    state_r <= CLEAR_SRC;
                end

                CLEAR_SRC: begin
                    if (game_over) begin
                        state_r <= OVER;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                OVER: begin
                    if (sel_evt_s || plc_evt_s) begin
                        err <= 1'b1;
                    end else begin
                        err <= 1'b0;
                    end
                end

                default: begin
                    state_r   <= IDLE;
                    chk_req   <= 1'b0;
                    sel_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chess_move_ctrl.sv
// Directed self-checking bench for chess_move_ctrl with a simple board
// memory and a hand-driven legality checker.
module tb_chess_move_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       select_btn = 1'b0;
    logic       place_btn = 1'b0;
    logic [2:0] cur_row = 3'd0;
    logic [2:0] cur_col = 3'd0;
    logic [2:0] rd_row, rd_col;
    logic [4:0] rd_data;
    logic       wr_en;
    logic [2:0] wr_row, wr_col;
    logic [4:0] wr_data;
    logic       chk_req;
    logic [4:0] chk_piece;
    logic [5:0] chk_src, chk_dst;
    logic       chk_ack = 1'b0;
    logic       chk_legal = 1'b0;
    logic       turn, sel_valid, err, move_done, game_over;
    logic [2:0] sel_row, sel_col;

    int checks = 0;
    int failures = 0;

    logic [4:0] board [0:63];
    int         wr_cnt = 0;
    logic       tb_clr = 1'b0;
    logic       tb_we = 1'b0;
    logic [5:0] tb_addr = 6'd0;
    logic [4:0] tb_wdata = 5'd0;

    chess_move_ctrl #(.CHK_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .select_btn(select_btn), .place_btn(place_btn),
        .cur_row(cur_row), .cur_col(cur_col), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .chk_req(chk_req), .chk_piece(chk_piece),
        .chk_src(chk_src), .chk_dst(chk_dst), .chk_ack(chk_ack),
        .chk_legal(chk_legal), .turn(turn), .sel_valid(sel_valid),
        .sel_row(sel_row), .sel_col(sel_col), .err(err),
        .move_done(move_done), .game_over(game_over)
    );

    always #5 clk = ~clk;

    assign rd_data = board[{rd_row, rd_col}];

    // Board memory: bench setup port plus the DUT write port (DUT wins)
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 64; i++) board[i] <= 5'd0;
        end else if (tb_we) begin
            board[tb_addr] <= tb_wdata;
        end
        if (wr_en) begin
            board[{wr_row, wr_col}] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic clear_board();
        @(negedge clk); tb_clr = 1'b1;
        @(negedge clk); tb_clr = 1'b0;
    endtask

    task automatic put_piece(input logic [2:0] r, input logic [2:0] c, input logic [4:0] code);
        @(negedge clk); tb_we = 1'b1; tb_addr = {r, c}; tb_wdata = code;
        @(negedge clk); tb_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0; chk_ack = 1'b0; chk_legal = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic press_select(input logic [2:0] r, input logic [2:0] c);
        @(negedge clk); cur_row = r; cur_col = c; select_btn = 1'b1;
        @(negedge clk); select_btn = 1'b0;
    endtask

    task automatic press_place(input logic [2:0] r, input logic [2:0] c);
        @(negedge clk); cur_row = r; cur_col = c; place_btn = 1'b1;
        @(negedge clk); place_btn = 1'b0;
    endtask

    // Called at the negedge of the first CHECK cycle; ack is sampled k cycles after chk_req rose
    task automatic give_ack(input int k, input logic legal);
        repeat (k - 1) @(negedge clk);
        chk_ack = 1'b1; chk_legal = legal;
        @(negedge clk);
        chk_ack = 1'b0; chk_legal = 1'b0;
    endtask

    task automatic test_reset();
        clear_board();
        put_piece(3'd6, 3'd4, 5'b00101);
        cur_row = 3'd6; cur_col = 3'd4; select_btn = 1'b1;
        do_reset();
        if (turn !== 1'b0) begin failures++; $display("FAIL rst_turn: got %0b want 0", turn); end
        checks++;
        if (sel_valid !== 1'b0 || chk_req !== 1'b0 || wr_en !== 1'b0) begin
            failures++; $display("FAIL rst_flags: sel_valid=%0b chk_req=%0b wr_en=%0b want 000", sel_valid, chk_req, wr_en);
        end
        checks++;
        if (err !== 1'b0 || move_done !== 1'b0 || game_over !== 1'b0) begin
            failures++; $display("FAIL rst_pulses: err=%0b move_done=%0b game_over=%0b want 000", err, move_done, game_over);
        end
        checks++;
        if ({sel_row, sel_col, chk_piece, chk_src, chk_dst, wr_row, wr_col, wr_data} !== 34'd0) begin
            failures++; $display("FAIL rst_buses: got %0h want 0", {sel_row, sel_col, chk_piece, chk_src, chk_dst, wr_row, wr_col, wr_data});
        end
        checks++;
        // Select held through reset must not become an event
        repeat (2) @(negedge clk);
        if (sel_valid !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL rst_held_btn: sel_valid=%0b err=%0b want 00", sel_valid, err);
        end
        checks++;
        select_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_legal_move();
        int w0;
        clear_board();
        put_piece(3'd6, 3'd4, 5'b00101);
        w0 = wr_cnt;
        press_select(3'd6, 3'd4);
        if (sel_valid !== 1'b1 || sel_row !== 3'd6 || sel_col !== 3'd4 || err !== 1'b0) begin
            failures++; $display("FAIL mv_select: sel=%0b row=%0d col=%0d err=%0b want 1 6 4 0", sel_valid, sel_row, sel_col, err);
        end
        checks++;
        press_place(3'd4, 3'd4);
        if (chk_req !== 1'b1 || chk_piece !== 5'b00101 || chk_src !== 6'b110100 || chk_dst !== 6'b100100) begin
            failures++; $display("FAIL mv_chk_bus: req=%0b piece=%b src=%b dst=%b want 1 00101 110100 100100", chk_req, chk_piece, chk_src, chk_dst);
        end
        checks++;
        @(negedge clk);
        @(negedge clk);
        if (chk_req !== 1'b1 || wr_en !== 1'b0 || chk_dst !== 6'b100100) begin
            failures++; $display("FAIL mv_chk_hold: req=%0b wr_en=%0b dst=%b want 1 0 100100", chk_req, wr_en, chk_dst);
        end
        checks++;
        chk_ack = 1'b1; chk_legal = 1'b1;
        @(negedge clk);
        chk_ack = 1'b0; chk_legal = 1'b0;
        if (wr_en !== 1'b1 || wr_row !== 3'd4 || wr_col !== 3'd4 || wr_data !== 5'b00101 || move_done !== 1'b0 || chk_req !== 1'b0) begin
            failures++; $display("FAIL mv_wr_dst: en=%0b r=%0d c=%0d d=%b done=%0b req=%0b want 1 4 4 00101 0 0", wr_en, wr_row, wr_col, wr_data, move_done, chk_req);
        end
        checks++;
        @(negedge clk);
        if (wr_en !== 1'b1 || wr_row !== 3'd6 || wr_col !== 3'd4 || wr_data !== 5'b00000 || move_done !== 1'b1 || turn !== 1'b1 || sel_valid !== 1'b0) begin
            failures++; $display("FAIL mv_clr_src: en=%0b r=%0d c=%0d d=%b done=%0b turn=%0b sel=%0b want 1 6 4 00000 1 1 0", wr_en, wr_row, wr_col, wr_data, move_done, turn, sel_valid);
        end
        checks++;
        @(negedge clk);
        if (wr_en !== 1'b0 || move_done !== 1'b0 || board[36] !== 5'b00101 || board[52] !== 5'b00000 || wr_cnt - w0 !== 2) begin
            failures++; $display("FAIL mv_board: en=%0b done=%0b b44=%b b64=%b writes=%0d want 0 0 00101 00000 2", wr_en, move_done, board[36], board[52], wr_cnt - w0);
        end
        checks++;
    endtask

    task automatic test_reset_in_check();
        int w0;
        put_piece(3'd1, 3'd3, 5'b00111);
        w0 = wr_cnt;
        press_select(3'd1, 3'd3);
        press_place(3'd2, 3'd3);
        if (chk_req !== 1'b1 || turn !== 1'b1) begin
            failures++; $display("FAIL rc_enter: req=%0b turn=%0b want 1 1", chk_req, turn);
        end
        checks++;
        reset = 1'b0;
        @(negedge clk);
        if (chk_req !== 1'b0 || turn !== 1'b0 || sel_valid !== 1'b0) begin
            failures++; $display("FAIL rc_after_rst: req=%0b turn=%0b sel=%0b want 0 0 0", chk_req, turn, sel_valid);
        end
        checks++;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk); cur_row = 3'd4; cur_col = 3'd4; select_btn = 1'b1; place_btn = 1'b1;
        @(negedge clk); select_btn = 1'b0; place_btn = 1'b0;
        if (err !== 1'b1 || sel_valid !== 1'b0 || chk_req !== 1'b0) begin
            failures++; $display("FAIL rc_both_evt: err=%0b sel=%0b req=%0b want 1 0 0", err, sel_valid, chk_req);
        end
        checks++;
        press_select(3'd4, 3'd4);
        if (sel_valid !== 1'b1 || err !== 1'b0 || wr_cnt - w0 !== 0) begin
            failures++; $display("FAIL rc_idle_sel: sel=%0b err=%0b writes=%0d want 1 0 0", sel_valid, err, wr_cnt - w0);
        end
        checks++;
    endtask

    task automatic test_wrong_colour();
        do_reset();
        clear_board();
        put_piece(3'd1, 3'd0, 5'b00111);
        press_select(3'd1, 3'd0);
        if (err !== 1'b1 || sel_valid !== 1'b0) begin
            failures++; $display("FAIL wc_err: err=%0b sel=%0b want 1 0", err, sel_valid);
        end
        checks++;
        @(negedge clk);
        if (err !== 1'b0 || chk_req !== 1'b0) begin
            failures++; $display("FAIL wc_pulse: err=%0b req=%0b want 0 0", err, chk_req);
        end
        checks++;
        press_place(3'd2, 3'd0);
        if (err !== 1'b1 || sel_valid !== 1'b0) begin
            failures++; $display("FAIL wc_idle_place: err=%0b sel=%0b want 1 0", err, sel_valid);
        end
        checks++;
    endtask

    task automatic test_own_capture();
        do_reset();
        clear_board();
        put_piece(3'd7, 3'd1, 5'b01001);
        put_piece(3'd6, 3'd3, 5'b00101);
        press_select(3'd7, 3'd1);
        press_place(3'd6, 3'd3);
        if (err !== 1'b1 || sel_valid !== 1'b1 || chk_req !== 1'b0) begin
            failures++; $display("FAIL oc_own_dst: err=%0b sel=%0b req=%0b want 1 1 0", err, sel_valid, chk_req);
        end
        checks++;
        press_place(3'd7, 3'd1);
        if (err !== 1'b1 || chk_req !== 1'b0) begin
            failures++; $display("FAIL oc_src_dst: err=%0b req=%0b want 1 0", err, chk_req);
        end
        checks++;
        press_select(3'd6, 3'd3);
        if (err !== 1'b0 || sel_row !== 3'd6 || sel_col !== 3'd3) begin
            failures++; $display("FAIL oc_reselect: err=%0b row=%0d col=%0d want 0 6 3", err, sel_row, sel_col);
        end
        checks++;
        press_select(3'd6, 3'd3);
        if (err !== 1'b0 || sel_valid !== 1'b0) begin
            failures++; $display("FAIL oc_deselect: err=%0b sel=%0b want 0 0", err, sel_valid);
        end
        checks++;
    endtask

    task automatic test_timeout();
        int n;
        int guard;
        int w0;
        do_reset();
        clear_board();
        put_piece(3'd7, 3'd1, 5'b01001);
        w0 = wr_cnt;
        press_select(3'd7, 3'd1);
        press_place(3'd5, 3'd2);
        n = 0;
        guard = 0;
        while (chk_req === 1'b1 && guard < 400) begin
            n++;
            guard++;
            @(negedge clk);
        end
        if (n !== 255) begin failures++; $display("FAIL to_req_len: got %0d want 255", n); end
        checks++;
        if (err !== 1'b1 || sel_valid !== 1'b0 || wr_cnt - w0 !== 0) begin
            failures++; $display("FAIL to_abort: err=%0b sel=%0b writes=%0d want 1 0 0", err, sel_valid, wr_cnt - w0);
        end
        checks++;
    endtask

    task automatic test_illegal();
        int w0;
        do_reset();
        clear_board();
        put_piece(3'd6, 3'd2, 5'b00101);
        w0 = wr_cnt;
        press_select(3'd6, 3'd2);
        press_place(3'd3, 3'd2);
        give_ack(2, 1'b0);
        if (err !== 1'b1 || sel_valid !== 1'b0 || chk_req !== 1'b0 || wr_en !== 1'b0 || turn !== 1'b0) begin
            failures++; $display("FAIL il_reject: err=%0b sel=%0b req=%0b wr=%0b turn=%0b want 1 0 0 0 0", err, sel_valid, chk_req, wr_en, turn);
        end
        checks++;
        @(negedge clk);
        if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL il_writes: got %0d want 0", wr_cnt - w0); end
        checks++;
    endtask

    task automatic test_king_capture();
        int w0;
        do_reset();
        clear_board();
        put_piece(3'd6, 3'd0, 5'b00101);
        put_piece(3'd4, 3'd4, 5'b10111);
        put_piece(3'd7, 3'd4, 5'b11001);
        press_select(3'd6, 3'd0);
        press_place(3'd5, 3'd0);
        give_ack(1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        if (turn !== 1'b1 || game_over !== 1'b0) begin
            failures++; $display("FAIL kc_white_move: turn=%0b over=%0b want 1 0", turn, game_over);
        end
        checks++;
        press_select(3'd4, 3'd4);
        press_place(3'd7, 3'd4);
        if (chk_piece !== 5'b10111 || chk_dst !== 6'b111100) begin
            failures++; $display("FAIL kc_chk_bus: piece=%b dst=%b want 10111 111100", chk_piece, chk_dst);
        end
        checks++;
        give_ack(1, 1'b1);
        if (wr_en !== 1'b1 || wr_row !== 3'd7 || wr_col !== 3'd4 || wr_data !== 5'b10111) begin
            failures++; $display("FAIL kc_wr_dst: en=%0b r=%0d c=%0d d=%b want 1 7 4 10111", wr_en, wr_row, wr_col, wr_data);
        end
        checks++;
        @(negedge clk);
        if (move_done !== 1'b1 || game_over !== 1'b1 || turn !== 1'b0) begin
            failures++; $display("FAIL kc_over: done=%0b over=%0b turn=%0b want 1 1 0", move_done, game_over, turn);
        end
        checks++;
        @(negedge clk);
        w0 = wr_cnt;
        if (board[60] !== 5'b10111 || board[36] !== 5'b00000) begin
            failures++; $display("FAIL kc_board: b74=%b b44=%b want 10111 00000", board[60], board[36]);
        end
        checks++;
        press_select(3'd5, 3'd0);
        if (err !== 1'b1 || sel_valid !== 1'b0 || game_over !== 1'b1) begin
            failures++; $display("FAIL kc_over_sel: err=%0b sel=%0b over=%0b want 1 0 1", err, sel_valid, game_over);
        end
        checks++;
        press_place(3'd3, 3'd3);
        if (err !== 1'b1 || chk_req !== 1'b0 || wr_cnt - w0 !== 0) begin
            failures++; $display("FAIL kc_over_place: err=%0b req=%0b writes=%0d want 1 0 0", err, chk_req, wr_cnt - w0);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_legal_move();
        test_reset_in_check();
        test_wrong_colour();
        test_own_capture();
        test_timeout();
        test_illegal();
        test_king_capture();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chess_move_ctrl.md
Name: chess_move_ctrl

Overview:
Turn-based move sequencer that sits between the cursor/button inputs and the board register array. It sequences each move: select a piece, place it, check legality, commit the move, and alternate turns.
- Legality is decided by an external move checker through a req/ack handshake.
- The block owns the only write port into the board array. The VGA path only reads the board.

Parameters:
CHK_TIMEOUT, 255, max cycles to wait for chk_ack before aborting the move
CW, $clog2(CHK_TIMEOUT+1), timeout counter width (derived, do not override)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
select_btn  in  1  select key level, already synchronised; rising edge = select event
place_btn  in  1  place key level, already synchronised; rising edge = place event
cur_row  in  3  cursor row
cur_col  in  3  cursor column
rd_row  out  3  board read address, row (driven = cur_row)
rd_col  out  3  board read address, column (driven = cur_col)
rd_data  in  5  board square code {type[4:2], color[1], occupied[0]}; combinational read
wr_en  out  1  board write strobe
wr_row  out  3  board write row
wr_col  out  3  board write column
wr_data  out  5  board write data
chk_req  out  1  legality request, held until chk_ack
chk_piece  out  5  piece code being moved
chk_src  out  6  {row,col} of source square
chk_dst  out  6  {row,col} of destination square
chk_ack  in  1  checker response valid (1-cycle pulse)
chk_legal  in  1  verdict, sampled only when chk_ack=1
turn  out  1  side to move: 0 = white, 1 = black
sel_valid  out  1  a piece is currently selected
sel_row  out  3  selected square row
sel_col  out  3  selected square column
err  out  1  1-cycle pulse on a rejected action
move_done  out  1  1-cycle pulse when a move is committed
game_over  out  1  sticky; set when a king is captured

Behaviour:
- Event detection: an event is a rising edge (registered previous level). The first cycle after reset deasserts cannot produce an event.
- Simultaneous select and place events: both are ignored and err pulses.
- Reset values (reset=0 at a clk edge):
  - state=IDLE, turn=0.
  - sel_valid, chk_req, wr_en, err, move_done, game_over all 0.
  - sel_row, sel_col, chk_* buses, wr_* buses all 0.
- States: IDLE, SELECTED, CHECK, WRITE_DST, CLEAR_SRC, OVER.
- IDLE:
  - Select event with rd_data[0]=1 and rd_data[1]=turn: latch piece, src=cursor, sel_valid=1, go to SELECTED.
  - Any other select event, or any place event: err, stay in IDLE.
- SELECTED:
  - Select event on the source square: deselect, go to IDLE, no err.
  - Select event on another own piece: re-latch piece and src, stay.
  - Select event on any other square: err, stay.
  - Place event where dst==src, or dst holds an own-colour piece: err, stay.
  - Other place event: latch dst and dst code, go to CHECK.
- CHECK:
  - chk_req=1 from the first CHECK cycle; chk_* buses stable while chk_req=1.
  - chk_ack with chk_legal=1: go to WRITE_DST.
  - chk_ack with chk_legal=0: err, clear selection, go to IDLE.
  - CHK_TIMEOUT cycles without chk_ack: err, clear selection, go to IDLE.
  - Button events are ignored.
- WRITE_DST (1 cycle):
  - wr_en=1, wr_row/wr_col=dst, wr_data=piece.
- CLEAR_SRC (1 cycle):
  - wr_en=1, wr_row/wr_col=src, wr_data=5'b00000.
  - move_done pulse, turn toggles, sel_valid=0.
  - If the latched dst code had type 3'b110 and occupied=1: game_over=1, go to OVER.
  - Otherwise go to IDLE.
- OVER: every event causes err; the only exit is reset.
- Latency from place event to move_done, with ack k cycles after chk_req rises: 1 (CHECK entry) + k + 2 cycles.
- Reset mid-move: a write not yet issued is abandoned. A completed WRITE_DST without CLEAR_SRC is not rolled back; board re-initialisation is handled by the board owner.
- wr_en is only ever 1 in WRITE_DST and CLEAR_SRC; at most 2 write cycles per move.
- Timeout counter: CW bits, cleared on CHECK entry, saturating.

Decomposition:
- Package chess_pkg:
  - typedef piece_t: 5-bit packed {type, color, occ}.
  - enum piece types: PAWN=1, KNIGHT=2, BISHOP=3, ROOK=4, QUEEN=5, KING=6.
  - constants EMPTY=5'b0, WHITE=0, BLACK=1.
  - ctrl_state_t enum.
- Sub-module btn_edge: rising-edge detector, 2 instances.

Test Plan:
- White pawn 5'b00101 at (6,4): select (6,4), place (4,4), ack legal after 3 cycles -> write (4,4)=00101, then (6,4)=00000, move_done, turn=1.
- turn=0, select black pawn 5'b00111 at (1,0) -> err pulse, sel_valid stays 0, state IDLE.
- Select white knight (7,1), place on (6,3) holding white pawn -> err, sel_valid=1, no chk_req.
- Select (7,1), place (5,2), checker never acks -> chk_req high exactly 255 cycles, then err, sel_valid=0, wr_en never asserted.
- Black queen 5'b10111 captures white king 5'b11001 at (7,4), ack legal -> write (7,4)=10111, game_over=1; later select/place events -> err only.
- Reset asserted in CHECK -> next cycle chk_req=0, turn=0, state IDLE; select and place edges in the same cycle -> err, no state change.
